// File: rtl/rstack_ctrl.sv
// Return-stack controller: owns sp/depth, caches top-of-stack in a register
// and drives a 1R/1W RAM (async read, sync write) holding the older entries.
module rstack_ctrl #(
  parameter int WIDTH      = 4,
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] top,
  output logic [WIDTH:0]        depth,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [WIDTH-1:0]      mem_dout_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  we,
  output logic [WIDTH-1:0]      mem_din_addr,
  output logic [DATA_WIDTH-1:0] mem_din
);

  localparam int              CAP_INT = SIZE + 1;
  localparam logic [WIDTH:0]  CAP     = CAP_INT[WIDTH:0];
  localparam logic [WIDTH:0]  ONE_D   = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_SP = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] sp;

  assign empty         = (depth == '0);
  assign full          = (depth == CAP);
  assign mem_dout_addr = sp - ONE_SP;
  assign mem_din_addr  = sp;
  assign mem_din       = top;

  // Old TOS spills to RAM only on a plain push into a non-empty, non-full stack.
  assign we = rst_n && !clear && push && !pop && !empty && !full;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sp        <= '0;
      depth     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push && !pop) begin
      if (empty) begin
        top   <= push_data;
        depth <= ONE_D;
      end else if (!full) begin
        sp    <= sp + ONE_SP;
        top   <= push_data;
        depth <= depth + ONE_D;
      end else begin
        overflow <= 1'b1;
      end
    end else if (pop && !push) begin
      if (depth > ONE_D) begin
        top   <= mem_dout;
        sp    <= sp - ONE_SP;
        depth <= depth - ONE_D;
      end else if (depth == ONE_D) begin
        top   <= '0;
        depth <= '0;
      end else begin
        underflow <= 1'b1;
      end
    end else if (push && pop) begin
      // Tail-call replace; on an empty stack the pop half is refused.
      top <= push_data;
      if (empty) begin
        depth     <= ONE_D;
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rstack_ctrl.sv
// Scoreboard bench for rstack_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them in the cycle they fall due.
module tb_rstack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, push, pop, clear;
  logic [12:0] push_data;
  logic [12:0] top, mem_dout, mem_din;
  logic [4:0]  depth;
  logic        empty, full, overflow, underflow, we;
  logic [3:0]  mem_dout_addr, mem_din_addr;
  logic [12:0] ram [16];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    bit          is_we;
    logic        we_e;
    logic [12:0] top_e;
    logic [4:0]  dep_e;
    logic        ovf_e;
    logic        unf_e;
    int          addr_e;
    string       name;
  } exp_t;

  exp_t q[$];

  rstack_ctrl #(.WIDTH(4), .SIZE(16), .DATA_WIDTH(13)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .push_data(push_data),
    .clear(clear), .top(top), .depth(depth), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .mem_dout_addr(mem_dout_addr),
    .mem_dout(mem_dout), .we(we), .mem_din_addr(mem_din_addr), .mem_din(mem_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (we) ram[mem_din_addr] <= mem_din;
  assign mem_dout = ram[mem_dout_addr];

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [20:0] act, req;
      e = q.pop_front();
      tests++;
      if (e.due < cyc) begin
        fails++;
        $display("FAIL %s: expectation missed (due %0d, now %0d)", e.name, e.due, cyc);
      end else if (e.is_we) begin
        if (we !== e.we_e) begin
          fails++;
          $display("FAIL %s we: got %b expected %b", e.name, we, e.we_e);
        end
      end else begin
        act = {top, depth, empty, full, overflow, underflow};
        req = {e.top_e, e.dep_e, (e.dep_e == 5'd0), (e.dep_e == 5'd17), e.ovf_e, e.unf_e};
        if (act !== req) begin
          fails++;
          $display("FAIL %s state: got top=%h depth=%0d empty=%b full=%b ovf=%b unf=%b expected top=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
                   e.name, top, depth, empty, full, overflow, underflow,
                   e.top_e, e.dep_e, req[3], req[2], e.ovf_e, e.unf_e);
        end
        if (e.addr_e >= 0) begin
          tests++;
          if (mem_dout_addr !== 4'(e.addr_e)) begin
            fails++;
            $display("FAIL %s rd_addr: got %0d expected %0d", e.name, mem_dout_addr, e.addr_e);
          end
        end
      end
    end
  end

  // Drive one cycle of inputs; expected we is checked this cycle, state next cycle.
  task automatic step(input string nm, input bit ps, input bit pp, input bit cl,
                      input bit rs, input logic [12:0] d, input logic ewe,
                      input logic [12:0] etop, input logic [4:0] edep,
                      input logic eovf, input logic eunf, input int eaddr = -1);
    exp_t e;
    push = ps; pop = pp; clear = cl; rst_n = rs; push_data = d;
    e.due = cyc; e.is_we = 1'b1; e.we_e = ewe; e.top_e = '0; e.dep_e = '0;
    e.ovf_e = 1'b0; e.unf_e = 1'b0; e.addr_e = -1; e.name = nm;
    q.push_back(e);
    e.due = cyc + 1; e.is_we = 1'b0; e.top_e = etop; e.dep_e = edep;
    e.ovf_e = eovf; e.unf_e = eunf; e.addr_e = eaddr;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic ram_chk(input string nm, input int a, input logic [12:0] v);
    tests++;
    if (ram[a] !== v) begin
      fails++;
      $display("FAIL %s: ram[%0d]=%h expected %h", nm, a, ram[a], v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; push_data = '0;
    @(posedge clk); #1;

    step("reset", 0,0,0,0, 13'h0, 0, 13'h000, 5'd0, 0, 0, 15);
    step("idle",  0,0,0,1, 13'h0, 0, 13'h000, 5'd0, 0, 0, 15);

    // basic push/pop
    step("push1", 1,0,0,1, 13'h001, 0, 13'h001, 5'd1, 0, 0);
    step("push2", 1,0,0,1, 13'h002, 1, 13'h002, 5'd2, 0, 0);
    step("push3", 1,0,0,1, 13'h003, 1, 13'h003, 5'd3, 0, 0);
    ram_chk("ram0", 0, 13'h001);
    ram_chk("ram1", 1, 13'h002);
    step("pop3",  0,1,0,1, 13'h0, 0, 13'h002, 5'd2, 0, 0);
    step("pop2",  0,1,0,1, 13'h0, 0, 13'h001, 5'd1, 0, 0);
    step("pop1",  0,1,0,1, 13'h0, 0, 13'h000, 5'd0, 0, 0, 15);

    // fill to capacity, overflow, drain
    for (int i = 0; i < 17; i++)
      step("fill", 1,0,0,1, 13'h100 + 13'(i), (i > 0), 13'h100 + 13'(i), 5'(i + 1), 0, 0);
    step("ovf_push", 1,0,0,1, 13'h1FF, 0, 13'h110, 5'd17, 1, 0);
    for (int j = 0; j < 17; j++)
      step("drain", 0,1,0,1, 13'h0, 0, (j < 16) ? 13'h10F - 13'(j) : 13'h000, 5'(16 - j), 1, 0);
    step("sp_home", 0,0,0,1, 13'h0, 0, 13'h000, 5'd0, 1, 0, 15);
    step("clr_ovf", 0,0,1,1, 13'h0, 0, 13'h000, 5'd0, 0, 0, 15);

    // underflow is sticky
    step("unf_pop",   0,1,0,1, 13'h0,   0, 13'h000, 5'd0, 0, 1);
    step("push_aa",   1,0,0,1, 13'h0AA, 0, 13'h0AA, 5'd1, 0, 1);
    step("pop_aa",    0,1,0,1, 13'h0,   0, 13'h000, 5'd0, 0, 1);
    step("pp_empty",  1,1,0,1, 13'h055, 0, 13'h055, 5'd1, 0, 1);
    step("clr_unf",   0,0,1,1, 13'h0,   0, 13'h000, 5'd0, 0, 0, 15);

    // tail-call replace
    step("tc_p10", 1,0,0,1, 13'h010, 0, 13'h010, 5'd1, 0, 0);
    step("tc_p20", 1,0,0,1, 13'h020, 1, 13'h020, 5'd2, 0, 0);
    step("tc_rep", 1,1,0,1, 13'h030, 0, 13'h030, 5'd2, 0, 0, 0);
    step("tc_pop", 0,1,0,1, 13'h0,   0, 13'h010, 5'd1, 0, 0);
    step("tc_pop2",0,1,0,1, 13'h0,   0, 13'h000, 5'd0, 0, 0);

    // clear beats a simultaneous push; reset mid-sequence
    for (int i = 0; i < 5; i++)
      step("pre_clr", 1,0,0,1, 13'h201 + 13'(i), (i > 0), 13'h201 + 13'(i), 5'(i + 1), 0, 0);
    step("clr_push", 1,0,1,1, 13'h3FF, 0, 13'h000, 5'd0, 0, 0, 15);
    for (int i = 0; i < 3; i++)
      step("pre_rst", 1,0,0,1, 13'h301 + 13'(i), (i > 0), 13'h301 + 13'(i), 5'(i + 1), 0, 0);
    step("rst_push", 1,0,0,0, 13'h3EE, 0, 13'h000, 5'd0, 0, 0, 15);
    step("post_rst", 0,0,0,1, 13'h0,   0, 13'h000, 5'd0, 0, 0, 15);

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain_queue: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
